// File: rtl/mcs_trace_capture_if.sv
// Trace-capture bus bundle: MCS retired-instruction trace inputs plus the
// valid/ready readout port of the frozen capture buffer.
interface mcs_trace_capture_if;
    logic        tr_valid_instr;
    logic [31:0] tr_pc;
    logic [31:0] tr_instruction;
    logic        tr_halted;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_pc;
    logic [31:0] rd_instr;
    logic        rd_last;

    // Environment side: drives the trace bus and accepts readout records.
    modport master (
        output tr_valid_instr, tr_pc, tr_instruction, tr_halted, rd_ready,
        input  rd_valid, rd_pc, rd_instr, rd_last
    );

    // Capture block side.
    modport slave (
        input  tr_valid_instr, tr_pc, tr_instruction, tr_halted, rd_ready,
        output rd_valid, rd_pc, rd_instr, rd_last
    );
endinterface

// File: rtl/mcs_trace_capture.sv
// MicroBlaze MCS trace capture: circular buffer of {pc, instr} records with a
// PC-match trigger, programmable post-trigger depth and oldest-first readout.
module mcs_trace_capture #(
    parameter int AW        = 4,
    parameter int POST_TRIG = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 arm,
    input  logic [31:0]          trig_pc,
    mcs_trace_capture_if.slave   bus,
    output logic                 busy,
    output logic                 triggered,
    output logic                 done,
    output logic [AW:0]          level
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] POST_L  = AW'(POST_TRIG);

    typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_POST, ST_DONE} state_t;

    state_t          state_r, state_s;
    logic [AW-1:0]   wr_ptr_r, wr_ptr_s;
    logic [AW:0]     level_r, level_s;
    logic [AW-1:0]   rem_r, rem_s;
    logic            trig_r, trig_s;
    logic [31:0]     trig_pc_r, trig_pc_s;
    logic            wr_en_s;
    logic [63:0]     mem_r [DEPTH];
    logic [AW-1:0]   rd_ptr_s;
    logic [63:0]     rd_rec_s;
    logic            rd_valid_s;

    // Next-state, pointer, level and trigger bookkeeping.
    always_comb begin
        state_s   = state_r;
        wr_ptr_s  = wr_ptr_r;
        level_s   = level_r;
        rem_s     = rem_r;
        trig_s    = trig_r;
        trig_pc_s = trig_pc_r;
        wr_en_s   = 1'b0;
        if (arm) begin
            // arm wins over everything, including a trace write this cycle
            state_s   = ST_PRE;
            wr_ptr_s  = {AW{1'b0}};
            level_s   = {(AW+1){1'b0}};
            trig_s    = 1'b0;
            trig_pc_s = trig_pc;
        end else begin
            case (state_r)
                ST_PRE, ST_POST: begin
                    if (bus.tr_valid_instr) begin
                        wr_en_s  = 1'b1;
                        wr_ptr_s = wr_ptr_r + AW'(1);
                        if (level_r == DEPTH_L) begin
                            level_s = level_r;
                        end else begin
                            level_s = level_r + (AW+1)'(1);
                        end
                        if (state_r == ST_POST) begin
                            rem_s = rem_r - AW'(1);
                            if (rem_r == AW'(1)) begin
                                state_s = ST_DONE;
                            end else begin
                                state_s = ST_POST;
                            end
                        end else if (bus.tr_pc == trig_pc_r) begin
                            trig_s = 1'b1;
                            if (POST_L == {AW{1'b0}}) begin
                                state_s = ST_DONE;
                            end else begin
                                rem_s   = POST_L;
                                state_s = ST_POST;
                            end
                        end else begin
                            state_s = state_r;
                        end
                    end else begin
                        wr_en_s = 1'b0;
                    end
                    // halt freezes the buffer; the write above still lands
                    if (bus.tr_halted) begin
                        state_s = ST_DONE;
                    end else begin
                        wr_en_s = wr_en_s;
                    end
                end
                ST_DONE: begin
                    if (level_r == {(AW+1){1'b0}}) begin
                        state_s = ST_IDLE;
                        trig_s  = 1'b0;
                    end else if (bus.rd_ready) begin
                        level_s = level_r - (AW+1)'(1);
                        if (level_r == (AW+1)'(1)) begin
                            state_s = ST_IDLE;
                            trig_s  = 1'b0;
                        end else begin
                            state_s = ST_DONE;
                        end
                    end else begin
                        state_s = ST_DONE;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State and bookkeeping registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            wr_ptr_r  <= {AW{1'b0}};
            level_r   <= {(AW+1){1'b0}};
            rem_r     <= {AW{1'b0}};
            trig_r    <= 1'b0;
            trig_pc_r <= 32'd0;
        end else begin
            state_r   <= state_s;
            wr_ptr_r  <= wr_ptr_s;
            level_r   <= level_s;
            rem_r     <= rem_s;
            trig_r    <= trig_s;
            trig_pc_r <= trig_pc_s;
        end
    end

    // Trace record storage; contents are only meaningful below level.
    always_ff @(posedge clk) begin
        if (wr_en_s && !reset) begin
            mem_r[wr_ptr_r] <= {bus.tr_pc, bus.tr_instruction};
        end
    end

    // Oldest valid entry sits level entries behind the write pointer.
    assign rd_ptr_s   = wr_ptr_r - level_r[AW-1:0];
    assign rd_rec_s   = mem_r[rd_ptr_s];
    assign rd_valid_s = (state_r == ST_DONE) && (level_r != {(AW+1){1'b0}});

    assign busy         = (state_r == ST_PRE) || (state_r == ST_POST);
    assign done         = (state_r == ST_DONE);
    assign triggered    = trig_r;
    assign level        = level_r;
    assign bus.rd_valid = rd_valid_s;
    assign bus.rd_last  = rd_valid_s && (level_r == (AW+1)'(1));
    assign bus.rd_pc    = rd_valid_s ? rd_rec_s[63:32] : 32'd0;
    assign bus.rd_instr = rd_valid_s ? rd_rec_s[31:0]  : 32'd0;
endmodule
